// File: rtl/multicycle_controller.sv
// multicycle_controller: sequencing FSM for the multicycle RV32I core.
// Walks each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath mux selects and write enables from the current state.
// Optional feature macro: MEM_WAIT_EN (memory states stall on MemReady=0).
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State,
    output logic       Retire
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    state_t     state;
    state_t     state_next;
    logic       mem_go;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       retire;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

`ifdef MEM_WAIT_EN
    assign mem_go = MemReady;
`else
    // Handshake is ignored in this build; memory states always complete.
    logic unused_memready;
    assign unused_memready = MemReady;
    assign mem_go          = 1'b1;
`endif

    // State register with synchronous reset to FETCH.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state and per-state control decode.
    always_comb begin
        state_next = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_go;
                pc_update  = mem_go;
                state_next = mem_go ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECUTER;
                    OP_ITYPE:          state_next = S_EXECUTEI;
                    OP_BEQ:            state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = mem_go ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                retire     = mem_go;
                state_next = mem_go ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // ALU operation decode from ALUOp and instruction fields.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format select straight from the opcode.
    always_comb begin
        case (op)
            OP_STORE: ImmSrc = 2'b01;
            OP_BEQ:   ImmSrc = 2'b10;
            OP_JAL:   ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Write enables are suppressed for the whole time reset is high.
    assign PCWrite   = ~reset & (pc_update | (branch & Zero));
    assign IRWrite   = ~reset & ir_write;
    assign RegWrite  = ~reset & reg_write;
    assign MemWrite  = ~reset & mem_write;
    assign Retire    = ~reset & retire;
    assign AdrSrc    = adr_src;
    assign ResultSrc = result_src;
    assign ALUSrcA   = alu_src_a;
    assign ALUSrcB   = alu_src_b;
    assign State     = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller with a per-instruction
// reference model (instruction class -> step list, step -> control outputs).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .State(State), .Retire(Retire)
    );

    always #5 clk = ~clk;

`ifdef MEM_WAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;
    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011, SLT = 3'b101;

    int    checks = 0;
    int    passed = 0;
    string cur_name;
    int    cyc_cnt, held_cnt, ret_cnt, mw_cnt, rw_cnt, pcw_cnt;
    logic [2:0] exec_alu;

    function automatic bit is_legal(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
    endfunction

    // Instruction latency in cycles without memory stalls.
    function automatic int latency(input logic [6:0] o);
        case (o)
            LW: return 5;
            SW, RT, IT, JL: return 4;
            BQ: return 3;
            default: return 2;
        endcase
    endfunction

    // Arithmetic operation the execute step must request.
    function automatic logic [2:0] exec_op(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o[5] && f7) ? SUB : ADD;
            3'b010:  return SLT;
            3'b110:  return OR_;
            3'b111:  return AND_;
            default: return ADD;
        endcase
    endfunction

    // Expected control word for one cycle of a given step.
    function automatic logic [20:0] expect_out(input logic [3:0] s, input logic [6:0] o,
            input logic [2:0] f3, input logic f7, input logic z, input logic rdy, input logic rst);
        logic pcw, adr, memw, irw, rw, ret, go;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        go = !(MW && (s == 4'd0 || s == 4'd3 || s == 4'd5)) || rdy;
        {pcw, adr, memw, irw, rw, ret} = 6'b0;
        rs = 2'b00; a = 2'b00; b = 2'b00; alu = ADD;
        case (s)
            4'd0:  begin irw = go; pcw = go; b = 2'b10; rs = 2'b10; end
            4'd1:  begin a = 2'b01; b = 2'b01; end
            4'd2:  begin a = 2'b10; b = 2'b01; end
            4'd3:  adr = 1'b1;
            4'd4:  begin rs = 2'b01; rw = 1'b1; ret = 1'b1; end
            4'd5:  begin adr = 1'b1; memw = 1'b1; ret = go; end
            4'd6:  begin a = 2'b10; alu = exec_op(o, f3, f7); end
            4'd7:  begin a = 2'b10; b = 2'b01; alu = exec_op(o, f3, f7); end
            4'd8:  begin rw = 1'b1; ret = 1'b1; end
            4'd9:  begin a = 2'b10; alu = SUB; ret = 1'b1; pcw = z; end
            4'd10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        case (o)
            SW: imm = 2'b01;
            BQ: imm = 2'b10;
            JL: imm = 2'b11;
            default: imm = 2'b00;
        endcase
        if (rst) {pcw, memw, irw, rw, ret} = 5'b0;
        return {s, pcw, adr, memw, irw, rw, rs, a, b, imm, alu, ret};
    endfunction

    // One clock cycle: apply inputs, compare full control word, advance.
    task automatic step(input logic [3:0] s, input logic rdy, input logic z, output logic adv);
        logic [20:0] exp_v, act_v;
        MemReady = rdy;
        Zero     = z;
        #1;
        exp_v = expect_out(s, op, funct3, funct7b5, z, rdy, reset);
        act_v = {State, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Retire};
        checks++;
        if (act_v !== exp_v)
            $display("FAIL %s step%0d: got %h expected %h (t=%0t)", cur_name, s, act_v, exp_v, $time);
        else
            passed++;
        cyc_cnt++;
        ret_cnt += int'(Retire);
        mw_cnt  += int'(MemWrite);
        rw_cnt  += int'(RegWrite);
        pcw_cnt += int'(PCWrite);
        if (s == 4'd6 || s == 4'd7) exec_alu = ALUControl;
        adv = !(MW && (s == 4'd0 || s == 4'd3 || s == 4'd5)) || rdy;
        if (!adv) held_cnt++;
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from FETCH; stall = zero-ready cycles per memory step (-1 random).
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int stall, input string name);
        int seq[5];
        int n;
        logic adv, z;
        cur_name = name;
        op = o; funct3 = f3; funct7b5 = f7;
        cyc_cnt = 0; held_cnt = 0; ret_cnt = 0; mw_cnt = 0; rw_cnt = 0; pcw_cnt = 0;
        exec_alu = 3'bxxx;
        case (o)
            LW: begin seq = '{0, 1, 2, 3, 4}; n = 5; end
            SW: begin seq = '{0, 1, 2, 5, 0}; n = 4; end
            RT: begin seq = '{0, 1, 6, 8, 0}; n = 4; end
            IT: begin seq = '{0, 1, 7, 8, 0}; n = 4; end
            BQ: begin seq = '{0, 1, 9, 0, 0}; n = 3; end
            JL: begin seq = '{0, 1, 10, 8, 0}; n = 4; end
            default: begin seq = '{0, 1, 0, 0, 0}; n = 2; end
        endcase
        for (int i = 0; i < n; i++) begin
            int nz;
            nz = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
            adv = 1'b0;
            while (!adv) begin
                z = (zmode == 2) ? 1'($urandom) : zmode[0];
                step(4'(seq[i]), (nz <= 0), z, adv);
                nz--;
            end
        end
        checks++;
        if (cyc_cnt - held_cnt !== latency(o))
            $display("FAIL %s latency: got %0d expected %0d", name, cyc_cnt - held_cnt, latency(o));
        else
            passed++;
        checks++;
        if (ret_cnt !== (is_legal(o) ? 1 : 0))
            $display("FAIL %s retire_count: got %0d expected %0d", name, ret_cnt, is_legal(o) ? 1 : 0);
        else
            passed++;
    endtask

    task automatic test_reset;
        cur_name = "reset";
        reset = 1'b1; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1; MemReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({State, PCWrite, IRWrite, RegWrite, MemWrite, Retire} !== 9'd0)
                $display("FAIL reset_hold: got state=%0d en=%b expected state=0 en=00000", State,
                         {PCWrite, IRWrite, RegWrite, MemWrite, Retire});
            else
                passed++;
        end
        reset = 1'b0;
    endtask

    task automatic test_lw;
        run_instr(LW, 3'b010, 1'b0, 2, 0, "lw");
        checks++;
        if (rw_cnt !== 1) $display("FAIL lw_regwrite_count: got %0d expected 1", rw_cnt);
        else passed++;
    endtask

    task automatic test_rtype;
        logic [2:0] want[3] = '{SUB, ADD, AND_};
        logic [2:0] f3s[3]  = '{3'b000, 3'b000, 3'b111};
        logic       f7s[3]  = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_instr(RT, f3s[i], f7s[i], 2, 0, "rtype");
            checks++;
            if (exec_alu !== want[i]) $display("FAIL rtype_alu%0d: got %b expected %b", i, exec_alu, want[i]);
            else passed++;
        end
        run_instr(IT, 3'b000, 1'b1, 2, 0, "addi_f7");
        checks++;
        if (exec_alu !== ADD) $display("FAIL addi_alu: got %b expected %b", exec_alu, ADD);
        else passed++;
    endtask

    task automatic test_beq;
        run_instr(BQ, 3'b000, 1'b0, 1, 0, "beq_taken");
        checks++;
        if (pcw_cnt !== 2) $display("FAIL beq_taken_pcwrite: got %0d expected 2", pcw_cnt);
        else passed++;
        run_instr(BQ, 3'b000, 1'b0, 0, 0, "beq_not_taken");
        checks++;
        if (pcw_cnt !== 1) $display("FAIL beq_nt_pcwrite: got %0d expected 1", pcw_cnt);
        else passed++;
    endtask

    task automatic test_jal_illegal;
        run_instr(JL, 3'b000, 1'b0, 2, 0, "jal");
        checks++;
        if ({pcw_cnt, rw_cnt} !== {32'd2, 32'd1})
            $display("FAIL jal_writes: got pcw=%0d rw=%0d expected pcw=2 rw=1", pcw_cnt, rw_cnt);
        else passed++;
        run_instr(7'b0000000, 3'b000, 1'b0, 2, 0, "illegal");
        checks++;
        if ({rw_cnt, mw_cnt} !== 64'd0)
            $display("FAIL illegal_writes: got rw=%0d mw=%0d expected 0 0", rw_cnt, mw_cnt);
        else passed++;
    endtask

    task automatic test_memready;
        run_instr(SW, 3'b010, 1'b0, 2, 3, "sw_stall");
        checks++;
        if (mw_cnt !== (MW ? 4 : 1))
            $display("FAIL sw_memwrite_cycles: got %0d expected %0d", mw_cnt, MW ? 4 : 1);
        else passed++;
        run_instr(LW, 3'b010, 1'b0, 2, 2, "lw_stall");
    endtask

    task automatic test_reset_mid;
        logic adv;
        cur_name = "reset_mid";
        op = LW; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int s = 0; s < 4; s++) step(4'(s), 1'b1, 1'b0, adv);
        reset = 1'b1;
        step(4'd4, 1'b1, 1'b0, adv);
        step(4'd0, 1'b1, 1'b1, adv);
        reset = 1'b0;
    endtask

    task automatic test_random;
        logic [6:0] ops[6] = '{LW, SW, RT, IT, BQ, JL};
        logic [6:0] o;
        for (int i = 0; i < 150; i++) begin
            int k;
            k = int'($urandom_range(0, 6));
            if (k < 6) o = ops[k];
            else begin
                o = 7'($urandom);
                if (is_legal(o)) o = 7'b1111111;
            end
            run_instr(o, 3'($urandom), 1'($urandom), 2, -1, "random");
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_rtype;
        test_beq;
        test_jal_illegal;
        test_memready;
        test_reset_mid;
        test_random;
        checks++;
        if (State !== 4'd0) $display("FAIL final_state: got %0d expected 0", State);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main sequencing controller for the multicycle RV32I core. Each instruction is split into 3–5 clock cycles, and the block drives every datapath mux select and write enable through a registered state machine: fetch, decode, execute, memory and writeback. A shared ALU and a single unified memory port serve both instruction fetch and data access. This block replaces the combinational decoder used in the single-cycle core.

## Interface
Parameters:
- none

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- op  in  7  instruction opcode (IR[6:0])
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory-ready handshake; used only when MEM_WAIT_EN is defined, otherwise ignored
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write strobe
- IRWrite  out  1  enables the IR and OldPC registers
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- State  out  4  current state encoding, for debug
- Retire  out  1  one-cycle pulse in the final cycle of each legal instruction

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTER = 6, EXECUTEI = 7, ALUWB = 8, BEQ = 9, JAL = 10.
- Encodings 11–15 are unreachable. If ever entered, the next state is FETCH and all enables are 0.

Per-state outputs. Any output not listed is 0; the ALUOp values 00/01/10 are internal.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Computes the branch target. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → FETCH, with no writes and no Retire
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: MEMREAD if op[5]=0, otherwise MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next state: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, Retire=1. Next state: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next state: FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, Retire=1. Next state: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state: ALUWB, which writes PC+4 to rd.

Derived outputs:
- PCWrite = PCUpdate | (Branch & Zero).
- ImmSrc is decoded combinationally from op:
  - lw / I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - any other op → 00
- ALU decoder:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 decodes funct3:
    - 000 → sub if {op[5], funct7b5} = 11, otherwise add
    - 010 → slt
    - 110 → or
    - 111 → and
    - any other funct3 → add

## Timing
- Outputs are combinational from the State register and the inputs.
- Reset:
  - While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and Retire are forced to 0.
  - On the first edge with reset=1, State becomes 0 (FETCH).
  - Reset asserted mid-instruction abandons the instruction with no further writes.
- Latency in cycles, without memory wait: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, jal 4, illegal 2.
- Branches: beq is taken when Zero=1 in the BEQ cycle. The PC is then loaded with the ALUOut value computed in DECODE.

## Configuration
- MEM_WAIT_EN defined:
  - FETCH, MEMREAD and MEMWRITE hold their state while MemReady=0.
  - During the hold, AdrSrc, MemWrite and the mux selects stay asserted.
  - IRWrite, PCUpdate and Retire assert only in the cycle where MemReady=1.
  - The state advances on that cycle.
- MEM_WAIT_EN undefined: MemReady is ignored and every state lasts exactly 1 cycle.

## Test plan
- **Reset:** reset=1 for 2 cycles → State=0, all enables 0. Release → cycle 0 shows FETCH with IRWrite=1, PCWrite=1, ALUSrcB=10.
- **lw** (op=0000011): FETCH→DECODE→MEMADR→MEMREAD→MEMWB over 5 cycles. RegWrite=1 and ResultSrc=01 only in cycle 5; Retire pulses once.
- **R-type sub** (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECUTER. The same instruction with funct7b5=0 gives 000. funct3=111 gives 010. Retire in cycle 4.
- **beq:** with Zero=1 → PCWrite=1 in cycle 3. With Zero=0 → PCWrite=0 in cycle 3. Either case returns to FETCH next.
- **jal then illegal op** (op=0000000): jal gives PCWrite=1 in JAL and RegWrite=1 in ALUWB. The illegal op returns DECODE→FETCH with no RegWrite, MemWrite or Retire.
- **MEM_WAIT_EN defined:** sw with MemReady held 0 for 3 cycles in MEMWRITE → MemWrite stays 1 for 4 cycles and Retire pulses only on the MemReady=1 cycle.
